// File: rtl/rv32_core_pkg.sv
// Shared RV32 core constants: format classes and opcode[6:2] values.
// Used by ir_sequencer, rv32_type_classifier and the decoder.
package rv32_core_pkg;

  localparam logic [2:0] TYPE_ILLEGAL = 3'd0;
  localparam logic [2:0] TYPE_R       = 3'd1;
  localparam logic [2:0] TYPE_I       = 3'd2;
  localparam logic [2:0] TYPE_S       = 3'd3;
  localparam logic [2:0] TYPE_B       = 3'd4;
  localparam logic [2:0] TYPE_U       = 3'd5;
  localparam logic [2:0] TYPE_J       = 3'd6;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_FENCE  = 5'b00011;
  localparam logic [4:0] OP_ALUI   = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_ALU    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

endpackage

// File: rtl/rv32_type_classifier.sv
// Combinational RV32 format classifier: opcode in, format class out.
// Non-32-bit encodings (opcode[1:0] != 2'b11) classify as illegal.
module rv32_type_classifier
  import rv32_core_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] instr_type
);

  logic [4:0] op;
  assign op = opcode[6:2];

  // Map opcode[6:2] onto its format class
  always_comb begin
    instr_type = TYPE_ILLEGAL;
    if (opcode[1:0] == 2'b11) begin
      unique case (1'b1)
        (op == OP_ALU):
          instr_type = TYPE_R;
        (op == OP_ALUI),
        (op == OP_LOAD),
        (op == OP_JALR),
        (op == OP_FENCE),
        (op == OP_SYSTEM):
          instr_type = TYPE_I;
        (op == OP_STORE):
          instr_type = TYPE_S;
        (op == OP_BRANCH):
          instr_type = TYPE_B;
        (op == OP_LUI),
        (op == OP_AUIPC):
          instr_type = TYPE_U;
        (op == OP_JAL):
          instr_type = TYPE_J;
        default:
          instr_type = TYPE_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/ir_sequencer.sv
// Instruction register, T-state counter and sticky halt for the RV32 core.
// Optional retired-instruction counter enabled by IR_SEQ_INSTRET_EN.
module ir_sequencer
  import rv32_core_pkg::*;
#(
  parameter int          T_WIDTH     = 3,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_wait,
  input  logic               ir_we,
  input  logic               T_rst,
  input  logic               hlt,
  output logic [31:0]        instr,
  output logic [6:0]         opcode,
  output logic [2:0]         funct3,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [4:0]         rd,
  output logic [2:0]         instr_type,
  output logic [T_WIDTH-1:0] T,
  output logic               halted,
  output logic [31:0]        instret
);

  logic ir_load;
  logic retire;

  assign ir_load = ir_we && !mem_wait && !halted;
  assign retire  = T_rst && !hlt && !halted && !mem_wait;

  // T-state and halt: halted > hlt > mem_wait > T_rst > increment
  always_ff @(posedge clk) begin
    if (rst) begin
      T      <= '0;
      halted <= 1'b0;
    end else if (halted) begin
      T <= T;
    end else if (hlt) begin
      halted <= 1'b1;
    end else if (mem_wait) begin
      T <= T;
    end else if (T_rst) begin
      T <= '0;
    end else begin
      T <= T + 1'b1;
    end
  end

  // Instruction register load from the memory data bus
  always_ff @(posedge clk) begin
    if (rst) begin
      instr <= RESET_INSTR;
    end else if (ir_load) begin
      instr <= mem_rdata;
    end
  end

`ifdef IR_SEQ_INSTRET_EN
  // Count instructions that actually retire
  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + 32'd1;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign instret = '0;
`endif

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  rv32_type_classifier u_cls (
    .opcode     (opcode),
    .instr_type (instr_type)
  );

endmodule

// File: tb/tb_ir_sequencer.sv
// Self-checking bench for ir_sequencer: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_ir_sequencer;

  localparam int TW = 3;
  localparam logic [31:0] RST_I = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   mem_rdata = '0;
  logic          mem_wait = 1'b0;
  logic          ir_we = 1'b0;
  logic          T_rst = 1'b0;
  logic          hlt = 1'b0;
  logic [31:0]   instr;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [4:0]    rs1, rs2, rd;
  logic [2:0]    instr_type;
  logic [TW-1:0] T;
  logic          halted;
  logic [31:0]   instret;

  int n_cmp = 0;
  int n_bad = 0;

  int          m_t;
  logic [31:0] m_instr;
  bit          m_halted;
  logic [31:0] m_instret;

  ir_sequencer #(.T_WIDTH(TW), .RESET_INSTR(RST_I)) dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata),
    .mem_wait(mem_wait), .ir_we(ir_we), .T_rst(T_rst),
    .hlt(hlt), .instr(instr), .opcode(opcode),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .rd(rd),
    .instr_type(instr_type), .T(T), .halted(halted),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_type(input logic [6:0] op);
    case (op)
      7'h33: return 1;
      7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: return 2;
      7'h23: return 3;
      7'h63: return 4;
      7'h37, 7'h17: return 5;
      7'h6F: return 6;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_t = 0;
      m_instr = RST_I;
      m_halted = 0;
      m_instret = 0;
    end else begin
      if (ir_we && !mem_wait && !m_halted)
        m_instr = mem_rdata;
      if (T_rst && !hlt && !m_halted && !mem_wait)
        m_instret = m_instret + 1;
      if (m_halted) begin
      end else if (hlt) begin
        m_halted = 1;
      end else if (mem_wait) begin
      end else if (T_rst) begin
        m_t = 0;
      end else begin
        m_t = (m_t + 1) % (1 << TW);
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_ir;
    exp_ir = m_instr;
    check("T", 32'(T), 32'(m_t));
    check("instr", instr, m_instr);
    check("halted", 32'(halted), 32'(m_halted));
    check("opcode", 32'(opcode), 32'(exp_ir[6:0]));
    check("funct3", 32'(funct3), 32'(exp_ir[14:12]));
    check("rs1", 32'(rs1), 32'(exp_ir[19:15]));
    check("rs2", 32'(rs2), 32'(exp_ir[24:20]));
    check("rd", 32'(rd), 32'(exp_ir[11:7]));
    check("type", 32'(instr_type), ref_type(exp_ir[6:0]));
`ifdef IR_SEQ_INSTRET_EN
    check("instret", instret, m_instret);
`else
    check("instret", instret, 32'd0);
`endif
  endtask

  task automatic drive(input bit r, input bit w, input bit we,
                       input bit tr, input bit h,
                       input logic [31:0] d);
    rst = r;
    mem_wait = w;
    ir_we = we;
    T_rst = tr;
    hlt = h;
    mem_rdata = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 32'h0);
  endtask

  logic [6:0] op_tab [14] = '{
    7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23,
    7'h63, 7'h37, 7'h17, 7'h6F, 7'h31, 7'h0B, 7'h7F
  };

  initial begin
    logic [31:0] d;
    m_t = 0; m_instr = RST_I; m_halted = 0; m_instret = 0;

    drive(1, 0, 0, 0, 0, 32'h0);
    drive(1, 0, 1, 1, 1, 32'hDEAD_BEEF);
    check("rst_T", 32'(T), 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_type", 32'(instr_type), 32'd2);
    check("rst_halted", 32'(halted), 32'd0);

    repeat (3) idle();
    check("idle_T3", 32'(T), 32'd3);
    drive(0, 0, 0, 1, 0, 32'h0);

    drive(0, 0, 1, 0, 0, 32'h00B5_0533);
    drive(0, 0, 0, 1, 0, 32'h0);
    check("add_instr", instr, 32'h00B5_0533);
    check("add_opcode", 32'(opcode), 32'h33);
    check("add_rd", 32'(rd), 32'd10);
    check("add_rs1", 32'(rs1), 32'd10);
    check("add_rs2", 32'(rs2), 32'd11);
    check("add_type", 32'(instr_type), 32'd1);
    check("add_T0", 32'(T), 32'd0);

    drive(0, 1, 1, 0, 0, 32'h00C5_8633);
    drive(0, 1, 1, 0, 0, 32'h00C5_8633);
    check("wait_T", 32'(T), 32'd0);
    check("wait_instr", instr, 32'h00B5_0533);
    drive(0, 0, 1, 0, 0, 32'h00C5_8633);
    check("wait_load", instr, 32'h00C5_8633);
    drive(0, 0, 0, 1, 0, 32'h0);

    drive(0, 0, 1, 0, 0, 32'h0000_0000);
    check("zero_type", 32'(instr_type), 32'd0);
    drive(0, 0, 0, 1, 1, 32'h0);
    check("hlt_halted", 32'(halted), 32'd1);
    check("hlt_T", 32'(T), 32'd1);
    drive(0, 0, 1, 0, 0, 32'h0010_0073);
    check("hlt_noload", instr, 32'h0);
    check("hlt_Thold", 32'(T), 32'd1);
    drive(1, 0, 0, 0, 0, 32'h0);
    check("unhalt", 32'(halted), 32'd0);
    check("unhalt_T", 32'(T), 32'd0);

    repeat (7) idle();
    check("wrap_T7", 32'(T), 32'd7);
    idle();
    check("wrap_T0", 32'(T), 32'd0);

    drive(1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      idle();
      drive(0, i == 3, 0, 1, 0, 32'h0);
      if (i == 3) drive(0, 0, 0, 1, 0, 32'h0);
    end
    check("sync_T", 32'(T), 32'd0);
    drive(1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      idle();
      drive(0, i == 2, 0, 1, 0, 32'h0);
    end
`ifdef IR_SEQ_INSTRET_EN
    check("instret4", instret, 32'd4);
`else
    check("instret0", instret, 32'd0);
`endif

    for (int i = 0; i < 1500; i++) begin
      d = $urandom;
      if ($urandom_range(1, 0) == 1)
        d[6:0] = op_tab[$urandom_range(13, 0)];
      drive($urandom_range(59, 0) == 0,
            $urandom_range(3, 0) == 0,
            $urandom_range(2, 0) == 0,
            $urandom_range(3, 0) == 0,
            $urandom_range(39, 0) == 0,
            d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ir_sequencer.md
Name: ir_sequencer

Overview:
- Upstream neighbour of the instruction decoder in the multi-cycle RV32 core.
- Owns the instruction register (IR) and the T-state counter, and latches halt.
- Presents the decoded instruction fields (opcode, funct3, rs1/rs2/rd, format type) and the current T-state to the decoder.
- Consumes the decoder's ir_we / T_rst / hlt strobes and stalls on a memory-wait handshake.

Parameters:
- T_WIDTH, 3, width of the T-state counter; wraps modulo 2^T_WIDTH.
- RESET_INSTR, 32'h00000013, IR value after reset (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_rdata  in  32  instruction word from memory data bus.
- mem_wait  in  1  memory not ready; holds T and blocks IR load.
- ir_we  in  1  decoder strobe: load IR from mem_rdata.
- T_rst  in  1  decoder strobe: end of instruction, T returns to 0.
- hlt  in  1  decoder strobe: stop the core.
- instr  out  32  current IR contents.
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- rd  out  5  instr[11:7].
- type  out  3  format class; 0 = illegal.
- T  out  T_WIDTH  current T-state.
- halted  out  1  sticky halt flag.
- instret  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge):
  - T=0, instr=RESET_INSTR, halted=0, instret=0.
  - rst has priority over every other input, including mid-instruction and while halted.
- T update priority, highest first:
  - rst
  - halted: T holds.
  - hlt: set halted, T holds.
  - mem_wait: T holds.
  - T_rst: T goes to 0.
  - otherwise T increments, modulo 2^T_WIDTH (7 wraps to 0).
- IR load:
  - instr <= mem_rdata when ir_we=1, mem_wait=0 and halted=0.
  - ir_we is sampled in any T; the decoder only asserts it in T0.
  - If ir_we and T_rst arrive in the same cycle, both take effect.
- Halt:
  - hlt=1 sets halted on the next edge.
  - halted stays 1 until rst, and blocks ir_we, T changes and instret.
  - hlt and T_rst together: halted wins; T holds its value.
- Field outputs are purely combinational slices of instr, so they are valid the cycle after a load (zero-latency from IR).
- Type classification is combinational from opcode[6:2], only when opcode[1:0]=2'b11; otherwise type=0.
  - 1 = R: 01100.
  - 2 = I: 00100, 00000, 11001, 00011, 11100.
  - 3 = S: 01000.
  - 4 = B: 11000.
  - 5 = U: 01101, 00101.
  - 6 = J: 11011.
  - all other opcodes: 0.
- mem_wait only gates T and the IR load; it does not block hlt.

Optional Feature:
- Macro: IR_SEQ_INSTRET_EN.
- Defined:
  - instret increments by 1 on each edge where T_rst=1, hlt=0, halted=0, mem_wait=0.
  - Wraps at 2^32.
  - Cleared by rst.
- Undefined: instret is tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package rv32_core_pkg holds:
  - the format-type constants (TYPE_ILLEGAL=0 … TYPE_J=6);
  - the opcode[6:2] constants (OP_ALU, OP_ALUI, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_BRANCH, OP_FENCE, OP_SYSTEM).
- The decoder uses the same package.
- One combinational sub-module, rv32_type_classifier (opcode in, type out).
- T counter, IR and halt flop stay in ir_sequencer.

Test Plan:
- Reset, then 3 idle cycles with no strobes -> T=0,1,2,3; instr=0x00000013; type=2; halted=0.
- T0 with mem_rdata=0x00B50533 (add x10,x10,x11), ir_we=1; next cycle T_rst=1 -> instr=0x00B50533, opcode=0x33, rd=10, rs1=10, rs2=11, type=1; T returns to 0.
- ir_we=1 with mem_wait=1 for 2 cycles, then mem_wait=0 -> T held at 0 and IR unchanged for 2 cycles; IR loads on the third edge.
- Load instr=0x00000000, then hlt=1 together with T_rst=1 -> type=0; halted=1; T held; a later ir_we with 0x00100073 leaves IR unchanged; rst clears halted and T.
- No strobes for 8 cycles from T=0 -> T sequence 1..7 then 0 (wrap).
- With IR_SEQ_INSTRET_EN: 5 instructions ended by T_rst, one T_rst coinciding with mem_wait=1 -> instret=4; without the macro -> instret=0.
